// File: rtl/single_divider_if.sv
// Operand/result bundle for single_divider: two operand channels and one result
// channel, each a stb/ack pair that transfers on an edge where both are high.
interface single_divider_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_a_stb,
        input  input_a_ack,
        output input_b, input_b_stb,
        input  input_b_ack,
        input  output_z, output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a, input_a_stb,
        output input_a_ack,
        input  input_b, input_b_stb,
        output input_b_ack,
        output output_z, output_z_stb,
        input  output_z_ack
    );
endinterface

// File: rtl/single_divider.sv
// IEEE-754 single-precision divider z = a / b: restoring mantissa division, RNE rounding.
// Define SINGLE_DIVIDER_DENORM_EN for subnormal operand and result support.
module single_divider (
    input  logic            clk,
    input  logic            rst,
    single_divider_if.slave bus,
    output logic [3:0]      state_dbg
);
    typedef enum logic [3:0] {
        st_get_a         = 4'd0,
        st_get_b         = 4'd1,
        st_unpack        = 4'd2,
        st_special_cases = 4'd3,
        st_normalise_a   = 4'd4,
        st_normalise_b   = 4'd5,
        st_divide_0      = 4'd6,
        st_divide_1      = 4'd7,
        st_divide_2      = 4'd8,
        st_divide_3      = 4'd9,
        st_normalise_1   = 4'd10,
        st_normalise_2   = 4'd11,
        st_round         = 4'd12,
        st_pack          = 4'd13,
        st_put_z         = 4'd14
    } state_t;

    state_t state, state_next;

    logic [31:0]        a, b, z, z_q;
    logic [23:0]        a_m, b_m, z_m;
    logic signed [9:0]  a_e, b_e, z_e;
    logic               a_s, b_s, z_s;
    logic               guard, round_bit, sticky;
    logic [49:0]        dividend;
    logic [23:0]        divisor;
    logic [26:0]        quotient;
    logic [25:0]        remainder;
    logic [5:0]         count;
    logic               a_ack_q, b_ack_q, z_stb_q;

    logic               a_is_max, b_is_max, a_is_min, b_is_min;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               special_hit;
    logic [31:0]        special_z;
    logic               z_sign;

    assign bus.input_a_ack  = a_ack_q;
    assign bus.input_b_ack  = b_ack_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_stb = z_stb_q;
    assign state_dbg        = state;

    // Exponent 128 is the all-ones field, -127 the all-zeros field.
    assign a_is_max = (a_e == 10'sd128);
    assign b_is_max = (b_e == 10'sd128);
    assign a_is_min = (a_e == -10'sd127);
    assign b_is_min = (b_e == -10'sd127);
    assign a_nan    = a_is_max && (a_m != 24'd0);
    assign b_nan    = b_is_max && (b_m != 24'd0);
    assign a_inf    = a_is_max && (a_m == 24'd0);
    assign b_inf    = b_is_max && (b_m == 24'd0);
`ifdef SINGLE_DIVIDER_DENORM_EN
    assign a_zero   = a_is_min && (a_m == 24'd0);
    assign b_zero   = b_is_min && (b_m == 24'd0);
`else
    assign a_zero   = a_is_min;
    assign b_zero   = b_is_min;
`endif
    assign z_sign   = a_s ^ b_s;

    always_comb begin
        special_hit = 1'b1;
        special_z   = 32'd0;
        if (a_nan || b_nan) begin
            special_z = 32'hFFC0_0000;
        end else if (a_inf && b_inf) begin
            special_z = 32'hFFC0_0000;
        end else if (a_inf) begin
            special_z = {z_sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            special_z = {z_sign, 31'd0};
        end else if (b_zero && a_zero) begin
            special_z = 32'hFFC0_0000;
        end else if (b_zero) begin
            special_z = {z_sign, 8'hFF, 23'd0};
        end else if (a_zero) begin
            special_z = {z_sign, 31'd0};
        end else begin
            special_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= st_get_a;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            st_get_a:         if (a_ack_q && bus.input_a_stb) state_next = st_get_b;
            st_get_b:         if (b_ack_q && bus.input_b_stb) state_next = st_unpack;
            st_unpack:        state_next = st_special_cases;
            st_special_cases: state_next = special_hit ? st_put_z : st_normalise_a;
`ifdef SINGLE_DIVIDER_DENORM_EN
            st_normalise_a:   if (a_m[23]) state_next = st_normalise_b;
            st_normalise_b:   if (b_m[23]) state_next = st_divide_0;
`else
            st_normalise_a:   state_next = st_normalise_b;
            st_normalise_b:   state_next = st_divide_0;
`endif
            st_divide_0:      state_next = st_divide_1;
            st_divide_1:      state_next = st_divide_2;
            st_divide_2:      state_next = (count == 6'd49) ? st_divide_3 : st_divide_1;
            st_divide_3:      state_next = st_normalise_1;
            st_normalise_1:   if (z_m[23]) state_next = st_normalise_2;
`ifdef SINGLE_DIVIDER_DENORM_EN
            st_normalise_2:   if (z_e >= -10'sd126) state_next = st_round;
`else
            st_normalise_2:   state_next = st_round;
`endif
            st_round:         state_next = st_pack;
            st_pack:          state_next = st_put_z;
            st_put_z:         if (z_stb_q && bus.output_z_ack) state_next = st_get_a;
            default:          state_next = st_get_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a         <= 32'd0;
            b         <= 32'd0;
            z         <= 32'd0;
            z_q       <= 32'd0;
            a_m       <= 24'd0;
            b_m       <= 24'd0;
            z_m       <= 24'd0;
            a_e       <= 10'sd0;
            b_e       <= 10'sd0;
            z_e       <= 10'sd0;
            a_s       <= 1'b0;
            b_s       <= 1'b0;
            z_s       <= 1'b0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            dividend  <= 50'd0;
            divisor   <= 24'd0;
            quotient  <= 27'd0;
            remainder <= 26'd0;
            count     <= 6'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            z_stb_q   <= 1'b0;
        end else begin
            case (state)
                st_get_a: begin
                    a_ack_q <= 1'b1;
                    if (a_ack_q && bus.input_a_stb) begin
                        a       <= bus.input_a;
                        a_ack_q <= 1'b0;
                    end
                end
                st_get_b: begin
                    b_ack_q <= 1'b1;
                    if (b_ack_q && bus.input_b_stb) begin
                        b       <= bus.input_b;
                        b_ack_q <= 1'b0;
                    end
                end
                st_unpack: begin
                    a_m <= {1'b0, a[22:0]};
                    b_m <= {1'b0, b[22:0]};
                    a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
                    b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
                    a_s <= a[31];
                    b_s <= b[31];
                end
                st_special_cases: begin
                    if (special_hit) begin
                        z <= special_z;
                    end else begin
`ifdef SINGLE_DIVIDER_DENORM_EN
                        if (a_is_min) a_e <= -10'sd126;
                        else          a_m[23] <= 1'b1;
                        if (b_is_min) b_e <= -10'sd126;
                        else          b_m[23] <= 1'b1;
`else
                        a_m[23] <= 1'b1;
                        b_m[23] <= 1'b1;
`endif
                    end
                end
`ifdef SINGLE_DIVIDER_DENORM_EN
                st_normalise_a: begin
                    if (!a_m[23]) begin
                        a_m <= {a_m[22:0], 1'b0};
                        a_e <= a_e - 10'sd1;
                    end
                end
                st_normalise_b: begin
                    if (!b_m[23]) begin
                        b_m <= {b_m[22:0], 1'b0};
                        b_e <= b_e - 10'sd1;
                    end
                end
`endif
                st_divide_0: begin
                    z_s       <= a_s ^ b_s;
                    z_e       <= a_e - b_e;
                    dividend  <= {a_m, 26'd0};
                    divisor   <= b_m;
                    quotient  <= 27'd0;
                    remainder <= 26'd0;
                    count     <= 6'd0;
                end
                st_divide_1: begin
                    quotient  <= {quotient[25:0], 1'b0};
                    remainder <= {remainder[24:0], dividend[49]};
                    dividend  <= {dividend[48:0], 1'b0};
                end
                st_divide_2: begin
                    if (remainder >= {2'b00, divisor}) begin
                        quotient[0] <= 1'b1;
                        remainder   <= remainder - {2'b00, divisor};
                    end
                    if (count != 6'd49) count <= count + 6'd1;
                end
                st_divide_3: begin
                    z_m       <= quotient[26:3];
                    guard     <= quotient[2];
                    round_bit <= quotient[1];
                    sticky    <= quotient[0] | (remainder != 26'd0);
                end
                st_normalise_1: begin
                    if (!z_m[23]) begin
                        z_m       <= {z_m[22:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                        z_e       <= z_e - 10'sd1;
                    end
                end
`ifdef SINGLE_DIVIDER_DENORM_EN
                st_normalise_2: begin
                    if (z_e < -10'sd126) begin
                        z_e       <= z_e + 10'sd1;
                        z_m       <= {1'b0, z_m[23:1]};
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                    end
                end
`endif
                st_round: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        z_m <= z_m + 24'd1;
                        if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
                    end
                end
                st_pack: begin
                    if (z_e > 10'sd127) begin
                        z <= {z_s, 8'hFF, 23'd0};
`ifndef SINGLE_DIVIDER_DENORM_EN
                    end else if (z_e < -10'sd126) begin
                        z <= {z_s, 31'd0};
`endif
                    end else if (z_e == -10'sd126 && !z_m[23]) begin
                        z <= {z_s, 8'h00, z_m[22:0]};
                    end else begin
                        z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]};
                    end
                end
                st_put_z: begin
                    // Capture only on entry so the result is frozen while offered.
                    if (!z_stb_q) begin
                        z_q     <= z;
                        z_stb_q <= 1'b1;
                    end else if (bus.output_z_ack) begin
                        z_stb_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
